// File: rtl/mure_ingress_serializer.sv
// Ingress serializer for the multiple-retirement trace path.
// Compacts up to NrRetiredInstr retired lanes plus one group-wide trap record
// per cycle into a circular buffer and hands out one entry per cycle over a
// valid/ready handshake.

package mure_pkg;
    localparam int XLEN      = 32;
    localparam int INST_LEN  = 32;
    localparam int CAUSE_LEN = 5;
    localparam int PRIV_LEN  = 2;

    // One buffered trace entry.
    typedef struct packed {
        logic                 iretired;
        logic [XLEN-1:0]      pc;
        logic [INST_LEN-1:0]  inst;
        logic                 compressed;
        logic                 exception;
        logic                 interrupt;
        logic                 eret;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic [PRIV_LEN-1:0]  priv_lvl;
    } trace_entry_t;
endpackage

// Per-lane entry builder: works out where this lane lands inside the group
// (number of valid lanes below it) and whether it carries the trap fields
// (no valid lane above it).
module mure_ingress_lane
    import mure_pkg::*;
#(
    parameter int NrRetiredInstr = 2,
    parameter int Lane           = 0,
    parameter int OffW           = 4
) (
    input  logic [NrRetiredInstr-1:0] valids_i,
    input  logic [XLEN-1:0]           pc_i,
    input  logic [INST_LEN-1:0]       inst_i,
    input  logic                      compressed_i,
    input  logic                      exception_i,
    input  logic                      interrupt_i,
    input  logic                      eret_i,
    input  logic [CAUSE_LEN-1:0]      cause_i,
    input  logic [XLEN-1:0]           tval_i,
    input  logic [PRIV_LEN-1:0]       priv_lvl_i,
    output trace_entry_t              entry_o,
    output logic [OffW-1:0]           offset_o
);

    logic is_last;

    // Slot offset within the group and last-valid-lane detection.
    always_comb begin
        offset_o = '0;
        is_last  = valids_i[Lane];
        for (int j = 0; j < NrRetiredInstr; j++) begin
            if (j < Lane && valids_i[j]) offset_o = offset_o + OffW'(1);
            if (j > Lane && valids_i[j]) is_last = 1'b0;
        end
    end

    // Entry contents; trap fields ride only on the last entry of the group.
    always_comb begin
        entry_o            = '0;
        entry_o.iretired   = 1'b1;
        entry_o.pc         = pc_i;
        entry_o.inst       = inst_i;
        entry_o.compressed = compressed_i;
        entry_o.priv_lvl   = priv_lvl_i;
        if (is_last) begin
            entry_o.exception = exception_i;
            entry_o.interrupt = interrupt_i;
            entry_o.eret      = eret_i;
            entry_o.cause     = cause_i;
            entry_o.tval      = tval_i;
        end
    end

endmodule

module mure_ingress_serializer
    import mure_pkg::*;
#(
    parameter int NrRetiredInstr = 2,
    parameter int FifoDepth      = 16,
    localparam int PtrW          = $clog2(FifoDepth),
    localparam int CntW          = PtrW + 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  logic [NrRetiredInstr-1:0]          valids_i,
    input  logic [NrRetiredInstr*XLEN-1:0]     pc_i,
    input  logic [NrRetiredInstr*INST_LEN-1:0] inst_i,
    input  logic [NrRetiredInstr-1:0]          compressed_i,
    input  logic                               exception_i,
    input  logic                               interrupt_i,
    input  logic                               eret_i,
    input  logic [CAUSE_LEN-1:0]               cause_i,
    input  logic [XLEN-1:0]                    tval_i,
    input  logic [PRIV_LEN-1:0]                priv_lvl_i,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic                               iretired_o,
    output logic [XLEN-1:0]                    pc_o,
    output logic [INST_LEN-1:0]                inst_data_o,
    output logic                               compressed_o,
    output logic                               exception_o,
    output logic                               interrupt_o,
    output logic                               eret_o,
    output logic [CAUSE_LEN-1:0]               cause_o,
    output logic [XLEN-1:0]                    tval_o,
    output logic [PRIV_LEN-1:0]                priv_lvl_o,
    output logic [CntW-1:0]                    usage_o,
    output logic                               overflow_o
);

    trace_entry_t                     mem [FifoDepth];
    logic [PtrW-1:0]                  rd_ptr, wr_ptr;
    logic [CntW-1:0]                  count;
    logic                             overflow_q;

    trace_entry_t [NrRetiredInstr-1:0] lane_entry;
    logic [NrRetiredInstr-1:0][PtrW-1:0] lane_off;
    trace_entry_t                     trap_entry;
    trace_entry_t                     head;

    logic [CntW-1:0] grp_k;
    logic [CntW-1:0] free_slots;
    logic            trap_only;
    logic            push, drop, pop;

    for (genvar i = 0; i < NrRetiredInstr; i++) begin : g_lane
        mure_ingress_lane #(
            .NrRetiredInstr (NrRetiredInstr),
            .Lane           (i),
            .OffW           (PtrW)
        ) u_lane (
            .valids_i     (valids_i),
            .pc_i         (pc_i[i*XLEN +: XLEN]),
            .inst_i       (inst_i[i*INST_LEN +: INST_LEN]),
            .compressed_i (compressed_i[i]),
            .exception_i  (exception_i),
            .interrupt_i  (interrupt_i),
            .eret_i       (eret_i),
            .cause_i      (cause_i),
            .tval_i       (tval_i),
            .priv_lvl_i   (priv_lvl_i),
            .entry_o      (lane_entry[i]),
            .offset_o     (lane_off[i])
        );
    end

    // Trap-only entry: no retired lane, just the trap record tagged with lane 0 pc.
    always_comb begin
        trap_entry           = '0;
        trap_entry.pc        = pc_i[XLEN-1:0];
        trap_entry.exception = exception_i;
        trap_entry.interrupt = interrupt_i;
        trap_entry.eret      = eret_i;
        trap_entry.cause     = cause_i;
        trap_entry.tval      = tval_i;
        trap_entry.priv_lvl  = priv_lvl_i;
    end

    // Group size and all-or-nothing admission against pre-pop occupancy.
    always_comb begin
        grp_k = '0;
        for (int i = 0; i < NrRetiredInstr; i++) begin
            grp_k = grp_k + CntW'(valids_i[i]);
        end
        trap_only = (valids_i == '0) && (exception_i || interrupt_i);
        if (trap_only) grp_k = CntW'(1);
        free_slots = CntW'(FifoDepth) - count;
        push       = !flush_i && (grp_k != '0) && (grp_k <= free_slots);
        drop       = !flush_i && (grp_k != '0) && (grp_k >  free_slots);
        pop        = valid_o && ready_i;
    end

    // Pointers, occupancy and sticky overflow; flush wins over everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else if (flush_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrW'(grp_k);
            if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
            count      <= count + (push ? grp_k : '0) - (pop ? CntW'(1) : '0);
            overflow_q <= overflow_q | drop;
        end
    end

    // Entry storage: valid lanes land contiguously from wr_ptr, lane order kept.
    always_ff @(posedge clk_i) begin
        if (push) begin
            if (trap_only) begin
                mem[wr_ptr] <= trap_entry;
            end else begin
                for (int i = 0; i < NrRetiredInstr; i++) begin
                    if (valids_i[i]) mem[wr_ptr + lane_off[i]] <= lane_entry[i];
                end
            end
        end
    end

    assign valid_o = (count != '0);
    // Outputs read as zero whenever nothing is available.
    assign head    = valid_o ? mem[rd_ptr] : '0;

    assign iretired_o   = head.iretired;
    assign pc_o         = head.pc;
    assign inst_data_o  = head.inst;
    assign compressed_o = head.compressed;
    assign exception_o  = head.exception;
    assign interrupt_o  = head.interrupt;
    assign eret_o       = head.eret;
    assign cause_o      = head.cause;
    assign tval_o       = head.tval;
    assign priv_lvl_o   = head.priv_lvl;
    assign usage_o      = count;
    assign overflow_o   = overflow_q;

endmodule

// File: doc/mure_ingress_serializer.md
# mure_ingress_serializer

Parametrised ingress stage for the multiple-retirement trace path. Each cycle it accepts up to NrRetiredInstr retired instructions plus one group-wide trap record from the CPU commit port. It compacts the valid lanes in lane order into a single circular buffer and emits one entry per cycle to the trace encoder over a valid/ready handshake. It replaces the fixed two-lane, unbuffered front end with configurable lane count and buffer depth, trap-only entries, whole-group overflow dropping and flush.

## Interface
- NrRetiredInstr, 2: commit lanes per cycle; must be ≥1.
- FifoDepth, 16: buffer entries; must be a power of two and ≥ NrRetiredInstr.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous and active-low.
- flush_i  in  1  synchronous clear of buffer and overflow flag.
- valids_i  in  NrRetiredInstr  per-lane retire valid.
- pc_i  in  NrRetiredInstr*XLEN  per-lane instruction address; lane i occupies bits [(i+1)*XLEN-1 : i*XLEN].
- inst_i  in  NrRetiredInstr*INST_LEN  per-lane opcode; same packing as pc_i.
- compressed_i  in  NrRetiredInstr  per-lane compressed flag.
- exception_i, interrupt_i, eret_i  in  1 each  group-wide trap and return events.
- cause_i  in  CAUSE_LEN  trap cause, already selected by privilege.
- tval_i  in  XLEN  trap value.
- priv_lvl_i  in  PRIV_LEN  current privilege.
- valid_o  out  1  head entry available.
- ready_i  in  1  encoder accepts head entry.
- iretired_o  out  1  head entry is a retired instruction; 0 means trap-only entry.
- pc_o  out  XLEN
- inst_data_o  out  INST_LEN
- compressed_o  out  1
- exception_o, interrupt_o, eret_o  out  1 each
- cause_o  out  CAUSE_LEN
- tval_o  out  XLEN
- priv_lvl_o  out  PRIV_LEN
- usage_o  out  $clog2(FifoDepth)+1  current occupancy.
- overflow_o  out  1  sticky: at least one group was dropped.

XLEN, INST_LEN, CAUSE_LEN and PRIV_LEN are taken from mure_pkg.

## Operation
- Storage: entry array of FifoDepth, read pointer rd_ptr, write pointer wr_ptr (both $clog2(FifoDepth) bits, wrap naturally), count register of $clog2(FifoDepth)+1 bits.
- Group size k:
  - k = popcount(valids_i) when any lane is valid.
  - k = 1 when no lane is valid and exception_i or interrupt_i is set (trap-only entry).
  - k = 0 otherwise.
  - eret_i with no valid lane produces nothing.
- Compaction: valid lanes are written in ascending lane index to wr_ptr, wr_ptr+1, …, wr_ptr+k-1 (mod FifoDepth). Invalid lanes leave no holes.
- Per-entry fields: pc, inst, compressed and iretired=1 come from the lane. priv_lvl is copied to every entry.
- Trap fields (exception, interrupt, eret, cause, tval) are attached only to the last entry of the group, i.e. the highest-index valid lane. All other entries carry zeros in these fields.
- Trap-only entry: iretired=0, pc = lane 0 pc_i, inst=0, compressed=0, trap fields as input.
- Admission: a group is accepted only if k ≤ FifoDepth − count, using the count before any same-cycle pop (conservative).
  - Otherwise the whole group is dropped, nothing is written, and overflow_o is set.
  - A group is never partially written.
- Pop: when valid_o && ready_i, rd_ptr advances by 1.
- Count update: count_next = count + (accepted ? k : 0) − (pop ? 1 : 0).
- valid_o = (count != 0). Output fields are read combinationally from entry[rd_ptr] and must be held stable while valid_o && !ready_i.
- flush_i: next cycle rd_ptr = wr_ptr = count = 0 and overflow_o = 0. Same-cycle input group and pop are discarded.
- Reset: pointers, count and overflow_o are 0, so valid_o=0 and usage_o=0. Entry array contents are don't-care, but all data outputs must read 0 while valid_o=0, i.e. they are gated by valid_o.

## Timing
- Latency: a group accepted at edge t is visible at the outputs after edge t (1 cycle). Its j-th entry is popped no earlier than cycle t+j with ready_i held high.
- Throughput: 1 entry out per cycle. Input sustains NrRetiredInstr entries per cycle until full.
- Simultaneous push and pop in the same cycle are both performed.
- usage_o and overflow_o are registered and reflect state after the last edge.
- overflow_o rises the cycle after the dropping edge. Only flush_i or reset clears it.
- Asserting rst_ni low mid-operation forces valid_o=0, usage_o=0 and overflow_o=0 immediately, without waiting for a clock edge.
- Wrap-around: pointer arithmetic is mod FifoDepth. Ordering is preserved across the wrap.

## Test plan
- N=2, depth 16, ready_i=1. One cycle of valids=2'b11 with lane0 pc 0x1000 and lane1 pc 0x1004 → valid_o in the next two cycles with pc_o 0x1000 then 0x1004, iretired_o=1, then valid_o=0.
- valids=2'b10, lane1 pc 0x2008, compressed_i=2'b10 → exactly one entry: pc_o 0x2008, compressed_o=1, usage_o 1 then 0.
- valids=2'b11, exception_i=1, cause 2, tval 0xDEAD → entry 0 has exception_o=0 and cause_o=0; entry 1 has exception_o=1, cause_o=2, tval_o=0xDEAD.
- valids=0, interrupt_i=1, cause 7, lane0 pc 0x3000 → one entry: iretired_o=0, interrupt_o=1, pc_o 0x3000, inst_data_o 0.
- ready_i=0; push 8 groups of 2 → usage_o=16. A 9th group is dropped, overflow_o=1 the next cycle and usage_o stays 16. Then ready_i=1 → 16 entries drain in order with correct wrap-around; overflow_o stays 1 until flush_i pulses, then reads 0.
- Two boundary cases:
  - count=15, push group of 2 with simultaneous pop → group dropped, usage_o=14.
  - Reset asserted with usage_o=5 → valid_o=0 and usage_o=0 immediately; after release, a new single push appears with the correct pc.
